// File: rtl/pc_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_fetch: OpenMIPS IF stage; owns the PC, fetches over a wait-state bus.    |
// | Optional misaligned-fetch trap: PC_FETCH_ALIGN_CHECK_EN.   Revision: 1.0    |
// +----------------------------------------------------------------------------+
module pc_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        stallreq_o,
  output logic        fetch_adel_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic        br_pending_q, br_pending_d;
  logic [31:0] br_target_q, br_target_d;
  logic [31:0] abort_addr_q, abort_addr_d;

  logic [31:0] fetch_addr;
  logic        misalign;
  logic        in_req;
  logic        ack_ok;
  logic        advance;
  logic        unused_stall;

  assign unused_stall = ^stall[5:1];
  assign in_req       = (state_q == S_REQ);

`ifdef PC_FETCH_ALIGN_CHECK_EN
  assign misalign   = in_req && (pc_q[1:0] != 2'b00);
  assign fetch_addr = pc_q;
`else
  assign misalign   = 1'b0;
  assign fetch_addr = {pc_q[31:2], 2'b00};
`endif

  // A trapped (misaligned) fetch never reaches the bus, so any ack is stray.
  assign ack_ok  = in_req && !misalign && imem_ack_i;
  assign advance = !flush && !stall[0] &&
                   ((in_req && ack_ok) || (state_q == S_HOLD));

  always_comb begin
    imem_req_o   = 1'b0;
    imem_addr_o  = 32'h0;
    if_pc_o      = pc_q;
    if_inst_o    = 32'h0;
    stallreq_o   = 1'b0;
    fetch_adel_o = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          imem_addr_o = fetch_addr;
          if_pc_o     = fetch_addr;
          stallreq_o  = 1'b1;
        end
        S_REQ: begin
          imem_req_o   = !misalign;
          imem_addr_o  = fetch_addr;
          if_pc_o      = fetch_addr;
          fetch_adel_o = misalign;
          if (ack_ok) begin
            if_inst_o = imem_rdata_i;
          end
          stallreq_o = !misalign && !imem_ack_i;
        end
        S_HOLD: begin
          imem_addr_o = fetch_addr;
          if_pc_o     = fetch_addr;
          if_inst_o   = hold_inst_q;
        end
        default: begin
          imem_req_o  = 1'b1;
          imem_addr_o = abort_addr_q;
          if_pc_o     = abort_addr_q;
          stallreq_o  = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_inst_d  = hold_inst_q;
    br_pending_d = br_pending_q;
    br_target_d  = br_target_q;
    abort_addr_d = abort_addr_q;
    if (flush) begin
      pc_d         = new_pc;
      br_pending_d = 1'b0;
      case (state_q)
        S_REQ: begin
          // Only an in-flight bus request needs its ack drained.
          if (!misalign && !imem_ack_i) begin
            state_d      = S_DISCARD;
            abort_addr_d = fetch_addr;
          end else begin
            state_d = S_REQ;
          end
        end
        S_DISCARD: state_d = imem_ack_i ? S_REQ : S_DISCARD;
        default:   state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (ack_ok && stall[0]) begin
            hold_inst_d = imem_rdata_i;
            state_d     = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall[0]) begin
            state_d = S_REQ;
          end
        end
        default: begin
          if (imem_ack_i) begin
            state_d = S_REQ;
          end
        end
      endcase
      if (advance) begin
        if (branch_flag_i) begin
          pc_d = branch_target_address_i;
        end else if (br_pending_q) begin
          pc_d = br_target_q;
        end else begin
          pc_d = pc_q + 32'd4;
        end
        br_pending_d = 1'b0;
      end else if (branch_flag_i) begin
        br_pending_d = 1'b1;
        br_target_d  = branch_target_address_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_VECTOR;
      hold_inst_q  <= 32'h0;
      br_pending_q <= 1'b0;
      br_target_q  <= 32'h0;
      abort_addr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_inst_q  <= hold_inst_d;
      br_pending_q <= br_pending_d;
      br_target_q  <= br_target_d;
      abort_addr_q <= abort_addr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pc_fetch: directed bench; memory returns addr+1.        Revision: 1.0    |
// +----------------------------------------------------------------------------+
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        stallreq_o;
  logic        fetch_adel_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign imem_rdata_i = imem_addr_o + 32'd1;

  pc_fetch dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .imem_req_o              (imem_req_o),
    .imem_addr_o             (imem_addr_o),
    .imem_ack_i              (imem_ack_i),
    .imem_rdata_i            (imem_rdata_i),
    .if_pc_o                 (if_pc_o),
    .if_inst_o               (if_inst_o),
    .stallreq_o              (stallreq_o),
    .fetch_adel_o            (fetch_adel_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 6'd0; flush = 1'b0; new_pc = 32'h0;
    branch_flag_i = 1'b0; branch_target_address_i = 32'h0; imem_ack_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({imem_req_o, stallreq_o, fetch_adel_o} !== 3'b000) begin errors++;
      $display("FAIL reset_ctrl got %b exp 000", {imem_req_o, stallreq_o, fetch_adel_o}); end
    checks++; if (if_inst_o !== 32'h0) begin errors++;
      $display("FAIL reset_inst got %h exp 00000000", if_inst_o); end
    checks++; if (if_pc_o !== 32'h0) begin errors++;
      $display("FAIL reset_pc got %h exp 00000000", if_pc_o); end
    rst = 1'b0;
    #1;
    checks++; if ({imem_req_o, stallreq_o, if_inst_o} !== {1'b0, 1'b1, 32'h0}) begin errors++;
      $display("FAIL idle got req=%b stallreq=%b inst=%h exp 0 1 0", imem_req_o, stallreq_o, if_inst_o); end
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({imem_req_o, imem_addr_o, if_inst_o, stallreq_o} !==
                    {1'b1, 32'(4 * i), 32'(4 * i + 1), 1'b0}) begin errors++;
        $display("FAIL zero_wait%0d got req=%b addr=%h inst=%h stallreq=%b exp 1 %h %h 0",
                 i, imem_req_o, imem_addr_o, if_inst_o, stallreq_o, 4 * i, 4 * i + 1); end
    end
  endtask

  task automatic test_wait_states();
    imem_ack_i = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if ({stallreq_o, if_inst_o, imem_addr_o} !== {1'b1, 32'h0, 32'h8}) begin errors++;
        $display("FAIL wait%0d got stallreq=%b inst=%h addr=%h exp 1 0 8", i, stallreq_o, if_inst_o, imem_addr_o); end
      if (i == 0) tick();
    end
    tick();
    imem_ack_i = 1'b1;
    #1;
    checks++; if ({stallreq_o, if_inst_o, if_pc_o} !== {1'b0, 32'h9, 32'h8}) begin errors++;
      $display("FAIL wait_ack got stallreq=%b inst=%h pc=%h exp 0 9 8", stallreq_o, if_inst_o, if_pc_o); end
    tick();
    checks++; if (imem_addr_o !== 32'hC) begin errors++;
      $display("FAIL wait_next got %h exp 0000000c", imem_addr_o); end
  endtask

  task automatic test_hold();
    stall = 6'b000001;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if ({imem_req_o, if_inst_o, stallreq_o, if_pc_o} !== {1'b0, 32'hD, 1'b0, 32'hC}) begin errors++;
        $display("FAIL hold%0d got req=%b inst=%h stallreq=%b pc=%h exp 0 d 0 c",
                 i, imem_req_o, if_inst_o, stallreq_o, if_pc_o); end
      if (i < 2) tick();
    end
    stall = 6'd0;
    tick();
    checks++; if ({imem_req_o, imem_addr_o, if_inst_o} !== {1'b1, 32'h10, 32'h11}) begin errors++;
      $display("FAIL hold_release got req=%b addr=%h inst=%h exp 1 10 11", imem_req_o, imem_addr_o, if_inst_o); end
  endtask

  task automatic test_branch();
    imem_ack_i = 1'b0; branch_flag_i = 1'b1; branch_target_address_i = 32'h100;
    tick();
    branch_flag_i = 1'b0;
    tick();
    imem_ack_i = 1'b1;
    #1;
    checks++; if ({if_inst_o, if_pc_o} !== {32'h11, 32'h10}) begin errors++;
      $display("FAIL br_ack got inst=%h pc=%h exp 11 10", if_inst_o, if_pc_o); end
    tick();
    checks++; if ({imem_addr_o, if_inst_o} !== {32'h100, 32'h101}) begin errors++;
      $display("FAIL br_pending got addr=%h inst=%h exp 100 101", imem_addr_o, if_inst_o); end
    branch_flag_i = 1'b1; branch_target_address_i = 32'h200;
    tick();
    branch_flag_i = 1'b0;
    checks++; if (imem_addr_o !== 32'h200) begin errors++;
      $display("FAIL br_live got %h exp 00000200", imem_addr_o); end
    imem_ack_i = 1'b0; branch_flag_i = 1'b1; branch_target_address_i = 32'h300;
    tick();
    imem_ack_i = 1'b1; branch_target_address_i = 32'h400;
    tick();
    branch_flag_i = 1'b0;
    checks++; if (imem_addr_o !== 32'h400) begin errors++;
      $display("FAIL br_live_beats_pending got %h exp 00000400", imem_addr_o); end
  endtask

  task automatic test_flush();
    imem_ack_i = 1'b0; flush = 1'b1; new_pc = 32'h80;
    branch_flag_i = 1'b1; branch_target_address_i = 32'h300;
    tick();
    flush = 1'b0; branch_flag_i = 1'b0;
    #1;
    checks++; if ({imem_req_o, imem_addr_o, if_inst_o, stallreq_o, if_pc_o} !==
                  {1'b1, 32'h400, 32'h0, 1'b1, 32'h400}) begin errors++;
      $display("FAIL discard got req=%b addr=%h inst=%h stallreq=%b pc=%h exp 1 400 0 1 400",
               imem_req_o, imem_addr_o, if_inst_o, stallreq_o, if_pc_o); end
    tick();
    imem_ack_i = 1'b1;
    #1;
    checks++; if ({imem_addr_o, if_inst_o, stallreq_o} !== {32'h400, 32'h0, 1'b1}) begin errors++;
      $display("FAIL discard_ack got addr=%h inst=%h stallreq=%b exp 400 0 1", imem_addr_o, if_inst_o, stallreq_o); end
    tick();
    checks++; if ({imem_req_o, imem_addr_o, if_inst_o} !== {1'b1, 32'h80, 32'h81}) begin errors++;
      $display("FAIL flush_resume got req=%b addr=%h inst=%h exp 1 80 81", imem_req_o, imem_addr_o, if_inst_o); end
  endtask

  task automatic test_wrap();
    flush = 1'b1; new_pc = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    checks++; if ({imem_addr_o, if_inst_o} !== {32'hFFFF_FFFC, 32'hFFFF_FFFD}) begin errors++;
      $display("FAIL wrap_top got addr=%h inst=%h exp fffffffc fffffffd", imem_addr_o, if_inst_o); end
    tick();
    checks++; if ({imem_addr_o, if_inst_o} !== {32'h0, 32'h1}) begin errors++;
      $display("FAIL wrap_zero got addr=%h inst=%h exp 0 1", imem_addr_o, if_inst_o); end
  endtask

  task automatic test_align();
    branch_flag_i = 1'b1; branch_target_address_i = 32'h102;
    tick();
    branch_flag_i = 1'b0;
`ifdef PC_FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 2; i++) begin
      checks++; if ({fetch_adel_o, imem_req_o, stallreq_o, if_inst_o} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin errors++;
        $display("FAIL adel%0d got adel=%b req=%b stallreq=%b inst=%h exp 1 0 0 0",
                 i, fetch_adel_o, imem_req_o, stallreq_o, if_inst_o); end
      if (i == 0) tick();
    end
    flush = 1'b1; new_pc = 32'h80;
    tick();
    flush = 1'b0;
    checks++; if ({fetch_adel_o, imem_req_o, imem_addr_o} !== {1'b0, 1'b1, 32'h80}) begin errors++;
      $display("FAIL adel_resume got adel=%b req=%b addr=%h exp 0 1 80", fetch_adel_o, imem_req_o, imem_addr_o); end
`else
    checks++; if ({fetch_adel_o, imem_addr_o, if_inst_o, if_pc_o} !== {1'b0, 32'h100, 32'h101, 32'h100}) begin errors++;
      $display("FAIL align_mask got adel=%b addr=%h inst=%h pc=%h exp 0 100 101 100",
               fetch_adel_o, imem_addr_o, if_inst_o, if_pc_o); end
`endif
  endtask

  task automatic test_reset_mid_fetch();
    imem_ack_i = 1'b0;
    tick();
    rst = 1'b1; imem_ack_i = 1'b1;
    #1;
    checks++; if ({imem_req_o, if_inst_o} !== {1'b0, 32'h0}) begin errors++;
      $display("FAIL rst_mid got req=%b inst=%h exp 0 0", imem_req_o, if_inst_o); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if ({if_pc_o, stallreq_o, imem_req_o} !== {32'h0, 1'b1, 1'b0}) begin errors++;
      $display("FAIL rst_mid_idle got pc=%h stallreq=%b req=%b exp 0 1 0", if_pc_o, stallreq_o, imem_req_o); end
    tick();
    checks++; if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0}) begin errors++;
      $display("FAIL rst_mid_req got req=%b addr=%h exp 1 0", imem_req_o, imem_addr_o); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_hold();
    test_branch();
    test_flush();
    test_wrap();
    test_align();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
